// File: rtl/serial_adder_driver_pkg.sv
// serial_adder_driver_pkg: shared state encoding, default width and counter sizing
package serial_adder_driver_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, CLR = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-load right-shift register presenting its LSB
// ports: clk, reset (sync, active-high), load (priority), shift, d (parallel in), lsb (serial out)
module piso_shift
    import serial_adder_driver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             lsb
);
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else if (load) q <= d;
        else if (shift) q <= {1'b0, q[WIDTH-1:1]};
    end
    assign lsb = q[0];
endmodule

// File: rtl/serial_adder_driver.sv
// serial_adder_driver: parallel front/back end feeding a bit-serial adder LSB-first and collecting its sum
// ports: clk, reset (sync, active-high); start/op_a/op_b request side; busy status;
//        ser_a/ser_b/ser_en/ser_clr to the adder, sum_bit from it; result/done/overflow completion side
module serial_adder_driver
    import serial_adder_driver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_en,
    output logic             ser_clr,
    input  logic             sum_bit,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             overflow
);
    localparam int CW = cnt_w(WIDTH);
    state_t         state;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] col;
    logic           sign_a, sign_b, a_lsb, b_lsb, accept;
    assign busy    = (state == CLR) || (state == SHIFT);
    assign ser_en  = state == SHIFT;
    assign ser_clr = state == CLR;
    assign done    = state == DONE;
    assign ser_a   = ser_en & a_lsb;
    assign ser_b   = ser_en & b_lsb;
    assign accept  = start && !busy;
    piso_shift #(.WIDTH(WIDTH)) u_a (
        .clk(clk), .reset(reset), .load(accept), .shift(ser_en), .d(op_a), .lsb(a_lsb)
    );
    piso_shift #(.WIDTH(WIDTH)) u_b (
        .clk(clk), .reset(reset), .load(accept), .shift(ser_en), .d(op_b), .lsb(b_lsb)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            col      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                sign_a <= op_a[WIDTH-1];
                sign_b <= op_b[WIDTH-1];
            end
            case (state)
                IDLE:  state <= start ? CLR : IDLE;
                CLR: begin
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    col <= {sum_bit, col[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // sum_bit is the final (MSB) sample, so the result sign is sum_bit itself
                        state    <= DONE;
                        result   <= {sum_bit, col[WIDTH-1:1]};
                        overflow <= (sign_a == sign_b) && (sum_bit != sign_a);
                    end
                end
                default: state <= start ? CLR : IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_driver.sv
// tb_serial_adder_driver: drives the driver against a behavioural serial adder and an arithmetic reference model
module tb_serial_adder_driver;
    logic       clk = 1'b0;
    logic       reset, start, busy, ser_a, ser_b, ser_en, ser_clr, sum_bit, done, overflow;
    logic [7:0] op_a, op_b, result;
    logic       carry;
    int         tests = 0, fails = 0;
    int         lat, ens, clr_at, en_first, en_last;
    logic [7:0] r;
    logic       o;
    typedef struct {logic [7:0] a; logic [7:0] b; logic [7:0] r; logic o;} vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    serial_adder_driver #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b), .busy(busy),
        .ser_a(ser_a), .ser_b(ser_b), .ser_en(ser_en), .ser_clr(ser_clr), .sum_bit(sum_bit),
        .result(result), .done(done), .overflow(overflow)
    );

    // stand-in for the serial adder FSM: carry state cleared by ser_clr, advanced by ser_en
    always_ff @(posedge clk) begin
        if (reset || ser_clr) carry <= 1'b0;
        else if (ser_en) carry <= (ser_a & ser_b) | (carry & (ser_a ^ ser_b));
    end
    assign sum_bit = ser_a ^ ser_b ^ carry;

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return {(s > 127) || (s < -128), 8'((int'(a) + int'(b)) % 256)};
    endfunction

    task automatic chk(input string n, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic do_add(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; ens = 0; clr_at = -1; en_first = -1; en_last = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ser_clr && clr_at < 0) clr_at = k;
            if (ser_en) begin
                ens++;
                if (en_first < 0) en_first = k;
                en_last = k;
            end
            if (ser_clr && ser_en) chk("clr_en_exclusive", 1, 0);
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
        r = result;
        o = overflow;
    endtask

    initial begin
        int d1, d2, dn;
        logic [7:0] ra, rb;
        logic [8:0] m;
        tbl[0] = '{8'h03, 8'h05, 8'h08, 1'b0};
        tbl[1] = '{8'h7F, 8'h01, 8'h80, 1'b1};
        tbl[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
        tbl[3] = '{8'hFF, 8'h01, 8'h00, 1'b0};
        tbl[4] = '{8'hF6, 8'h03, 8'hF9, 1'b0};
        tbl[5] = '{8'hC0, 8'hBF, 8'h7F, 1'b1};
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {ser_a, ser_b, ser_en, ser_clr, done, overflow}, 0);
        chk("rst_result", result, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            do_add(tbl[i].a, tbl[i].b);
            chk($sformatf("vec%0d_result", i), r, tbl[i].r);
            chk($sformatf("vec%0d_ovf", i), o, tbl[i].o);
            chk($sformatf("vec%0d_latency", i), lat, 10);
            chk($sformatf("vec%0d_en_count", i), ens, 8);
            chk($sformatf("vec%0d_clr_cycle", i), clr_at, 1);
            chk($sformatf("vec%0d_en_window", i), en_first * 100 + en_last, 209);
        end

        // start held high across two adds, operands changed mid-shift
        @(negedge clk);
        op_a = 8'h11; op_b = 8'h22; start = 1'b1;
        @(posedge clk);
        d1 = -1; d2 = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 4) begin
                op_a = 8'h55; op_b = 8'h66;
            end
            if (d1 > 0 && k == d1 + 1) chk("b2b_clr_follows", ser_clr, 1);
            if (k == 15) chk("b2b_result_held", result, 8'h33);
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    chk("b2b_first_result", result, 8'h33);
                    chk("b2b_first_ovf", overflow, 0);
                end else begin
                    d2 = k;
                    chk("b2b_second_result", result, 8'hBB);
                    chk("b2b_second_ovf", overflow, 1);
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_latency", d1, 10);
        chk("b2b_spacing", d2 - d1, 10);

        // reset during the 4th shift cycle
        @(negedge clk);
        op_a = 8'h40; op_b = 8'h40; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_in_shift", ser_en, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ser_en", ser_en, 0);
        chk("rst_mid_result", result, 0);
        chk("rst_mid_flags", {done, overflow, ser_clr, ser_a, ser_b}, 0);
        reset = 1'b0;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("rst_mid_no_done", dn, 0);
        do_add(8'h10, 8'h20);
        chk("post_rst_result", r, 8'h30);
        chk("post_rst_ovf", o, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            m  = model(ra, rb);
            do_add(ra, rb);
            chk("rand_result", r, m[7:0]);
            chk("rand_ovf", o, m[8]);
            chk("rand_en_count", ens, 8);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
